// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Round-robin right-of-way controller for NUM_DIRS approaches. Every green is
// followed by a fixed yellow then all-red clearance. Phase timings live in a
// small register file, and an emergency preempt can steer the grant.
module traffic_phase_scheduler #(
  parameter  int NUM_DIRS      = 4,
  parameter  int TIMER_W       = 8,
  parameter  int DEF_MIN_GREEN = 100,
  parameter  int DEF_MAX_GREEN = 200,
  parameter  int DEF_YELLOW    = 20,
  parameter  int DEF_ALL_RED   = 4,
  localparam int DIR_W         = $clog2(NUM_DIRS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_DIRS-1:0] req,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [TIMER_W-1:0]  cfg_wdata,
  input  logic                preempt_valid,
  input  logic [DIR_W-1:0]    preempt_dir,
  output logic [NUM_DIRS-1:0] green,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] red,
  output logic [DIR_W-1:0]    active_dir,
  output logic [1:0]          phase
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } state_e;

  state_e               r_state;
  state_e               w_next;
  logic                 w_grant;
  logic [TIMER_W-1:0]   r_timer;
  logic [DIR_W-1:0]     r_dir;
  logic [DIR_W-1:0]     r_rr_ptr;
  logic [TIMER_W-1:0]   r_min_green;
  logic [TIMER_W-1:0]   r_max_green;
  logic [TIMER_W-1:0]   r_yellow;
  logic [TIMER_W-1:0]   r_all_red;

  logic [DIR_W-1:0]     w_pick;
  logic [DIR_W-1:0]     w_idx;
  logic                 w_found;
  logic [NUM_DIRS-1:0]  w_dir_oh;
  logic                 w_other;
  logic [TIMER_W-1:0]   w_min_m1;
  logic [TIMER_W-1:0]   w_max_m1;
  logic [TIMER_W-1:0]   w_eff_max_m1;
  logic [TIMER_W-1:0]   w_yellow_m1;
  logic [TIMER_W-1:0]   w_all_red_m1;

  // A programmed 0 behaves as 1; returns (effective value - 1) for
  // direct comparison against the zero-based phase timer.
  function automatic logic [TIMER_W-1:0] eff_m1(input logic [TIMER_W-1:0] v);
    return (v == '0) ? '0 : v - TIMER_W'(1);
  endfunction

  assign w_min_m1     = eff_m1(r_min_green);
  assign w_max_m1     = eff_m1(r_max_green);
  assign w_eff_max_m1 = (w_max_m1 > w_min_m1) ? w_max_m1 : w_min_m1;
  assign w_yellow_m1  = eff_m1(r_yellow);
  assign w_all_red_m1 = eff_m1(r_all_red);

  assign w_dir_oh = {{(NUM_DIRS-1){1'b0}}, 1'b1} << r_dir;
  assign w_other  = |(req & ~w_dir_oh);

  // Arbitration: preempt wins, otherwise first requester after the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    w_pick  = r_rr_ptr;
    w_idx   = '0;
    w_found = 1'b0;
    if (preempt_valid) begin
      w_pick = preempt_dir;
    end else begin
      for (int k = 1; k <= NUM_DIRS; k++) begin
        w_idx = DIR_W'((int'(r_rr_ptr) + k) % NUM_DIRS);
        if (!w_found && req[w_idx]) begin
          w_pick  = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  // Next-state logic for the phase sequencer.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (preempt_valid || (|req)) begin
          w_next  = ST_GREEN;
          w_grant = 1'b1;
        end
      end
      ST_GREEN: begin
        if (preempt_valid) begin
          // Preempt to another approach ends the green regardless of min.
          if (preempt_dir != r_dir) w_next = ST_YELLOW;
        end else if (w_other &&
                     (((r_timer >= w_min_m1) && !req[r_dir]) ||
                      (r_timer >= w_eff_max_m1))) begin
          w_next = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (r_timer >= w_yellow_m1) w_next = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (r_timer >= w_all_red_m1) begin
          if (preempt_valid || (|req)) begin
            w_next  = ST_GREEN;
            w_grant = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Phase state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Phase timer: zero on entry to each state, saturating count afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_timer <= '0;
    else if (w_next != r_state) r_timer <= '0;
    else if (r_timer != '1)     r_timer <= r_timer + TIMER_W'(1);
  end

  // Granted direction and round-robin pointer advance together on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir    <= '0;
      r_rr_ptr <= DIR_W'(NUM_DIRS - 1);
    end else if (w_grant) begin
      r_dir    <= w_pick;
      r_rr_ptr <= w_pick;
    end
  end

  // Timing register file; a write is seen by the comparators one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these registers are reset to working defaults so the controller
    // runs sensibly before software ever programs it.
    if (!rst_n) begin
      r_min_green <= TIMER_W'(DEF_MIN_GREEN);
      r_max_green <= TIMER_W'(DEF_MAX_GREEN);
      r_yellow    <= TIMER_W'(DEF_YELLOW);
      r_all_red   <= TIMER_W'(DEF_ALL_RED);
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    r_min_green <= cfg_wdata;
        2'd1:    r_max_green <= cfg_wdata;
        2'd2:    r_yellow    <= cfg_wdata;
        default: r_all_red   <= cfg_wdata;
      endcase
    end
  end

  assign green      = (r_state == ST_GREEN)  ? w_dir_oh : '0;
  assign yellow     = (r_state == ST_YELLOW) ? w_dir_oh : '0;
  assign red        = ~(green | yellow);
  assign active_dir = r_dir;
  assign phase      = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: table of phase segments
// plus a hand-written reset-during-yellow sequence, all checked through an
// expectation queue.
module tb_traffic_phase_scheduler;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_GREEN = 2'd1;
  localparam logic [1:0] P_YEL   = 2'd2;
  localparam logic [1:0] P_AR    = 2'd3;

  logic       clk           = 1'b0;
  logic       rst_n         = 1'b1;
  logic [3:0] req           = '0;
  logic       cfg_we        = 1'b0;
  logic [1:0] cfg_addr      = '0;
  logic [7:0] cfg_wdata     = '0;
  logic       preempt_valid = 1'b0;
  logic [1:0] preempt_dir   = '0;
  logic [3:0] green, yellow, red;
  logic [1:0] active_dir, phase;

  traffic_phase_scheduler #(
    .NUM_DIRS(4), .TIMER_W(8), .DEF_MIN_GREEN(100), .DEF_MAX_GREEN(200),
    .DEF_YELLOW(20), .DEF_ALL_RED(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .preempt_valid(preempt_valid), .preempt_dir(preempt_dir),
    .green(green), .yellow(yellow), .red(red), .active_dir(active_dir), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef enum {OP_RST, OP_CFG, OP_RUN} op_e;
  typedef struct {
    string      lbl;
    op_e        op;
    logic [3:0] req;
    logic       pv;
    logic [1:0] pd;
    logic [1:0] addr;
    logic [7:0] data;
    int         n;
    logic [1:0] ph;
    logic [1:0] dir;
  } vec_t;
  vec_t vecs[$];

  wire [15:0] obs = {phase, active_dir, green, yellow, red};

  // Expected lamp picture for a phase/direction pair.
  function automatic logic [15:0] mk(logic [1:0] ph, logic [1:0] dir);
    logic [3:0] oh, g, y;
    oh = 4'b0001 << dir;
    g  = (ph == P_GREEN) ? oh : 4'b0000;
    y  = (ph == P_YEL)   ? oh : 4'b0000;
    return {ph, dir, g, y, ~(g | y)};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got phase=%0d dir=%0d g=%b y=%b r=%b, want phase=%0d dir=%0d g=%b y=%b r=%b",
               name, act[15:14], act[13:12], act[11:8], act[7:4], act[3:0],
               exp[15:14], exp[13:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic compare_head();
    sb_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = sb.pop_front();
      check(e.name, obs, e.exp);
    end
  endtask

  // One clock: drive inputs, queue expectation, sample after the edge.
  task automatic step(logic [3:0] r, logic pv, logic [1:0] pd, logic we,
                      logic [1:0] a, logic [7:0] d, logic [1:0] ph,
                      logic [1:0] dir, string nm);
    req           = r;
    preempt_valid = pv;
    preempt_dir   = pd;
    cfg_we        = we;
    cfg_addr      = a;
    cfg_wdata     = d;
    sb.push_back('{nm, mk(ph, dir)});
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    compare_head();
  endtask

  function automatic vec_t v_run(string l, logic [3:0] r, logic pv, logic [1:0] pd,
                                 int n, logic [1:0] ph, logic [1:0] dir);
    vec_t v;
    v.lbl = l; v.op = OP_RUN; v.req = r; v.pv = pv; v.pd = pd;
    v.addr = '0; v.data = '0; v.n = n; v.ph = ph; v.dir = dir;
    return v;
  endfunction

  function automatic vec_t v_cfg(string l, logic [1:0] a, logic [7:0] d,
                                 logic [3:0] r, logic [1:0] ph, logic [1:0] dir);
    vec_t v;
    v = v_run(l, r, 1'b0, 2'd0, 1, ph, dir);
    v.op = OP_CFG; v.addr = a; v.data = d;
    return v;
  endfunction

  function automatic vec_t v_rst(string l);
    vec_t v;
    v = v_run(l, 4'b0000, 1'b0, 2'd0, 0, P_IDLE, 2'd0);
    v.op = OP_RST;
    return v;
  endfunction

  task automatic add_init(string l, logic [7:0] mn, logic [7:0] mx,
                          logic [7:0] y, logic [7:0] a);
    vecs.push_back(v_rst(l));
    vecs.push_back(v_cfg(l, 2'd0, mn, 4'b0000, P_IDLE, 2'd0));
    vecs.push_back(v_cfg(l, 2'd1, mx, 4'b0000, P_IDLE, 2'd0));
    vecs.push_back(v_cfg(l, 2'd2, y,  4'b0000, P_IDLE, 2'd0));
    vecs.push_back(v_cfg(l, 2'd3, a,  4'b0000, P_IDLE, 2'd0));
  endtask

  task automatic apply(vec_t v, int idx);
    case (v.op)
      OP_RST: begin
        req = '0; preempt_valid = 1'b0; cfg_we = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.push_back('{$sformatf("%s.v%0d.reset", v.lbl, idx), mk(P_IDLE, 2'd0)});
        compare_head();
        #1;
        rst_n = 1'b1;
      end
      OP_CFG: step(v.req, v.pv, v.pd, 1'b1, v.addr, v.data, v.ph, v.dir,
                   $sformatf("%s.v%0d.cfg", v.lbl, idx));
      default: begin
        for (int c = 0; c < v.n; c++)
          step(v.req, v.pv, v.pd, 1'b0, 2'd0, 8'd0, v.ph, v.dir,
               $sformatf("%s.v%0d.c%0d", v.lbl, idx, c));
      end
    endcase
  endtask

  initial begin
    // Rest on green with a single requester.
    add_init("rest", 8'd4, 8'd8, 8'd2, 8'd1);
    vecs.push_back(v_run("rest", 4'b0001, 0, 0, 61, P_GREEN, 2'd0));
    // Contention with req[0] held: max green applies.
    add_init("max", 8'd4, 8'd8, 8'd2, 8'd1);
    vecs.push_back(v_run("max", 4'b0101, 0, 0, 8, P_GREEN, 2'd0));
    vecs.push_back(v_run("max", 4'b0101, 0, 0, 2, P_YEL,   2'd0));
    vecs.push_back(v_run("max", 4'b0101, 0, 0, 1, P_AR,    2'd0));
    vecs.push_back(v_run("max", 4'b0101, 0, 0, 8, P_GREEN, 2'd2));
    vecs.push_back(v_run("max", 4'b0101, 0, 0, 2, P_YEL,   2'd2));
    vecs.push_back(v_run("max", 4'b0101, 0, 0, 1, P_AR,    2'd2));
    vecs.push_back(v_run("max", 4'b0101, 0, 0, 1, P_GREEN, 2'd0));
    // req[0] dropped on entry: min green applies.
    add_init("min", 8'd4, 8'd8, 8'd2, 8'd1);
    vecs.push_back(v_run("min", 4'b0101, 0, 0, 1,  P_GREEN, 2'd0));
    vecs.push_back(v_run("min", 4'b0100, 0, 0, 3,  P_GREEN, 2'd0));
    vecs.push_back(v_run("min", 4'b0100, 0, 0, 2,  P_YEL,   2'd0));
    vecs.push_back(v_run("min", 4'b0100, 0, 0, 1,  P_AR,    2'd0));
    vecs.push_back(v_run("min", 4'b0100, 0, 0, 10, P_GREEN, 2'd2));
    // All approaches requesting: full rotation 0,1,2,3,0.
    add_init("rr", 8'd4, 8'd8, 8'd2, 8'd1);
    for (int d = 0; d < 4; d++) begin
      vecs.push_back(v_run("rr", 4'b1111, 0, 0, 8, P_GREEN, 2'(d)));
      vecs.push_back(v_run("rr", 4'b1111, 0, 0, 2, P_YEL,   2'(d)));
      vecs.push_back(v_run("rr", 4'b1111, 0, 0, 1, P_AR,    2'(d)));
    end
    vecs.push_back(v_run("rr", 4'b1111, 0, 0, 1, P_GREEN, 2'd0));
    // Preempt mid-green, hold past max, retarget, then release.
    add_init("pre", 8'd4, 8'd8, 8'd2, 8'd1);
    vecs.push_back(v_run("pre", 4'b1111, 0, 2'd0, 2,  P_GREEN, 2'd0));
    vecs.push_back(v_run("pre", 4'b1111, 1, 2'd3, 2,  P_YEL,   2'd0));
    vecs.push_back(v_run("pre", 4'b1111, 1, 2'd3, 1,  P_AR,    2'd0));
    vecs.push_back(v_run("pre", 4'b1111, 1, 2'd3, 20, P_GREEN, 2'd3));
    vecs.push_back(v_run("pre", 4'b1111, 1, 2'd1, 2,  P_YEL,   2'd3));
    vecs.push_back(v_run("pre", 4'b1111, 1, 2'd1, 1,  P_AR,    2'd3));
    vecs.push_back(v_run("pre", 4'b1111, 1, 2'd1, 1,  P_GREEN, 2'd1));
    vecs.push_back(v_run("pre", 4'b1111, 0, 2'd0, 7,  P_GREEN, 2'd1));
    vecs.push_back(v_run("pre", 4'b1111, 0, 2'd0, 2,  P_YEL,   2'd1));
    vecs.push_back(v_run("pre", 4'b1111, 0, 2'd0, 1,  P_AR,    2'd1));
    vecs.push_back(v_run("pre", 4'b1111, 0, 2'd0, 1,  P_GREEN, 2'd2));
    // Zero yellow acts as 1; max below min uses min.
    add_init("zero", 8'd4, 8'd2, 8'd0, 8'd1);
    vecs.push_back(v_run("zero", 4'b0011, 0, 0, 4, P_GREEN, 2'd0));
    vecs.push_back(v_run("zero", 4'b0011, 0, 0, 1, P_YEL,   2'd0));
    vecs.push_back(v_run("zero", 4'b0011, 0, 0, 1, P_AR,    2'd0));
    vecs.push_back(v_run("zero", 4'b0011, 0, 0, 1, P_GREEN, 2'd1));
    // Write coinciding with the deciding compare does not alter it;
    // the new max applies to the following green.
    add_init("wr", 8'd4, 8'd8, 8'd2, 8'd1);
    vecs.push_back(v_run("wr", 4'b0101, 0, 0, 8, P_GREEN, 2'd0));
    vecs.push_back(v_cfg("wr", 2'd1, 8'd20, 4'b0101, P_YEL, 2'd0));
    vecs.push_back(v_run("wr", 4'b0101, 0, 0, 1,  P_YEL,   2'd0));
    vecs.push_back(v_run("wr", 4'b0101, 0, 0, 1,  P_AR,    2'd0));
    vecs.push_back(v_run("wr", 4'b0101, 0, 0, 20, P_GREEN, 2'd2));
    vecs.push_back(v_run("wr", 4'b0101, 0, 0, 1,  P_YEL,   2'd2));

    #2;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: asynchronous reset during yellow of direction 1,
    // then default timings are back in force.
    apply(v_rst("arst"), 900);
    apply(v_cfg("arst", 2'd0, 8'd4, 4'b0000, P_IDLE, 2'd0), 901);
    apply(v_cfg("arst", 2'd1, 8'd8, 4'b0000, P_IDLE, 2'd0), 902);
    apply(v_cfg("arst", 2'd2, 8'd2, 4'b0000, P_IDLE, 2'd0), 903);
    apply(v_cfg("arst", 2'd3, 8'd1, 4'b0000, P_IDLE, 2'd0), 904);
    apply(v_run("arst", 4'b1111, 0, 0, 8, P_GREEN, 2'd0), 905);
    apply(v_run("arst", 4'b1111, 0, 0, 2, P_YEL,   2'd0), 906);
    apply(v_run("arst", 4'b1111, 0, 0, 1, P_AR,    2'd0), 907);
    apply(v_run("arst", 4'b1111, 0, 0, 8, P_GREEN, 2'd1), 908);
    apply(v_run("arst", 4'b1111, 0, 0, 1, P_YEL,   2'd1), 909);
    apply(v_rst("arst"), 910);
    apply(v_run("arst", 4'b0011, 0, 0, 1,  P_GREEN, 2'd0), 911);
    apply(v_run("arst", 4'b0010, 0, 0, 99, P_GREEN, 2'd0), 912);
    apply(v_run("arst", 4'b0010, 0, 0, 20, P_YEL,   2'd0), 913);
    apply(v_run("arst", 4'b0010, 0, 0, 4,  P_AR,    2'd0), 914);
    apply(v_run("arst", 4'b0010, 0, 0, 1,  P_GREEN, 2'd1), 915);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Multi-approach intersection controller that shares a single "right-of-way" resource among NUM_DIRS approaches.
- Each approach has a car sensor. Green phases are granted round-robin, and every green is followed by a fixed yellow/all-red clearance sequence.
- The four phase timings are configured through a simple register write port. An emergency preempt input forces the right-of-way to a chosen direction.
- Sits above the per-light output drivers. It generalises the two-way main/side light controller to N approaches.

Parameters:
- NUM_DIRS, 4, number of approaches (2..8); DIR_W = clog2(NUM_DIRS), local.
- TIMER_W, 8, width of phase timer and timing registers.
- DEF_MIN_GREEN, 100, reset value of min-green register (cycles).
- DEF_MAX_GREEN, 200, reset value of max-green register (cycles).
- DEF_YELLOW, 20, reset value of yellow register (cycles).
- DEF_ALL_RED, 4, reset value of all-red clearance register (cycles).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_DIRS  sensor level per approach, 1 = car waiting.
- cfg_we  in  1  config write strobe, one write per cycle.
- cfg_addr  in  2  0=min_green, 1=max_green, 2=yellow, 3=all_red.
- cfg_wdata  in  TIMER_W  config write data.
- preempt_valid  in  1  emergency preempt active (level).
- preempt_dir  in  DIR_W  direction to preempt to.
- green  out  NUM_DIRS  one-hot green lamp.
- yellow  out  NUM_DIRS  one-hot yellow lamp.
- red  out  NUM_DIRS  red lamp = ~(green|yellow).
- active_dir  out  DIR_W  currently/last granted direction.
- phase  out  2  0=IDLE, 1=GREEN, 2=YELLOW, 3=ALL_RED.

Behaviour:
- Reset (async, immediate):
  - phase=IDLE, active_dir=0, green=0, yellow=0, red=all ones, timer=0.
  - Config registers load DEF_*; round-robin pointer=NUM_DIRS-1, so direction 0 has first priority.
- Timer:
  - Cleared to 0 on the first cycle of every state, then increments by 1 per cycle.
  - Saturates at all ones; it never wraps while resting on green.
- Effective timings:
  - A register value of 0 is used as 1.
  - eff_max = max(max_green, min_green).
  - Comparisons always use the current register value. A write takes effect on the next cycle, including for the state already in progress.
- Arbitration pick:
  - If preempt_valid, pick = preempt_dir.
  - Otherwise pick = first direction with req set, searching from (rr_ptr+1) mod NUM_DIRS upward with wrap.
  - The pointer updates to pick on each grant.
  - A sole requester may be re-granted consecutively.
- IDLE (all red):
  - If preempt_valid or any req, go to GREEN with active_dir=pick on the next edge; otherwise stay.
  - Latency from request to green lamp is 1 cycle.
- GREEN:
  - green[active_dir]=1. Let other = any req[i] with i != active_dir.
  - Go to YELLOW if preempt_valid and preempt_dir != active_dir. This ignores min_green.
  - Otherwise, if preempt_valid and preempt_dir == active_dir, stay green (max_green ignored).
  - Otherwise go to YELLOW if other and either condition holds:
    - timer >= min-1 and !req[active_dir];
    - timer >= eff_max-1.
  - With no other request, rest on green indefinitely.
- YELLOW:
  - yellow[active_dir]=1 for exactly `yellow` cycles, then ALL_RED. Cannot be shortened by preempt.
- ALL_RED:
  - All red for exactly `all_red` cycles, then:
    - GREEN with active_dir=pick, if preempt_valid or any req;
    - otherwise IDLE.
  - active_dir keeps its old value through YELLOW, ALL_RED and IDLE.
- Simultaneous events:
  - A cfg write in the same cycle as a timer comparison does not affect that comparison.
  - A preempt asserting in the last YELLOW cycle still gets the full all-red.
  - preempt_dir changing during GREEN on the preempted direction triggers YELLOW on the next edge.
- Invariants:
  - At most one bit of green|yellow is set.
  - green and yellow are never both nonzero.
  - Every transition away from a green passes through YELLOW then ALL_RED.

Test Plan:
- Reset, write min=4, max=8, yellow=2, all_red=1, then req=0001 held -> phase GREEN, green=0001 one cycle later; remains green for 50+ cycles with no other request.
- Direction 0 green, then req=0101 held -> green 0001 lasts 8 cycles, yellow 0001 for 2, all-red 1, then green=0100. Repeat with req[0] dropped at entry -> green lasts 4 cycles.
- req=1111 held, same config -> grant order 0,1,2,3,0; each green lasts 8 cycles; red is the complement of green|yellow every cycle.
- Direction 0 green at timer=1, preempt_valid=1, preempt_dir=3 -> yellow 0001 next cycle for 2 cycles, all-red 1, green=1000. Held beyond 8 cycles while preempt stays high with req=1111.
- Write yellow=0, max=2, min=4 -> yellow lasts 1 cycle; green lasts 4 cycles under contention (eff_max=min).
- rst_n low mid-YELLOW -> green=0, yellow=0, red=all ones, phase=0 immediately without a clock edge. After release, timings are back to the DEF values (green lasts 100 cycles under req=0011 with req[0] dropped).
